// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: pixel counters and player events in, game status out.
// master drives the pixel counters and events; slave is the controller.
interface pong_game_ctrl_if;
   logic [11:0] pixel_x;
   logic [11:0] pixel_y;
   logic [1:0]  btn;
   logic        hit;
   logic        miss;
   logic        frame_tick;
   logic [1:0]  state;
   logic        gra_still;
   logic [1:0]  text_sel;
   logic [7:0]  score;
   logic [2:0]  balls_left;
   logic        timer_done;

   modport master (
      output pixel_x, pixel_y, btn, hit, miss,
      input  frame_tick, state, gra_still, text_sel, score, balls_left, timer_done
   );

   modport slave (
      input  pixel_x, pixel_y, btn, hit, miss,
      output frame_tick, state, gra_still, text_sel, score, balls_left, timer_done
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick, game FSM, BCD score, balls and frame countdown.
// All outputs registered, 1 clk from the causing input; no backpressure, events are pulses.
module pong_game_ctrl #(
   parameter int VD_LINE      = 480,
   parameter int TIMER_FRAMES = 120,
   parameter int BALLS        = 3
) (
   input  logic            clk,
   input  logic            rst,
   pong_game_ctrl_if.slave bus
);

   localparam int TW = $clog2(TIMER_FRAMES + 1);

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      NEWBALL = 2'b10,
      OVER    = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic            at_vb, at_vb_q, tick_q;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            done_q;
   logic            timer_load;
   logic [3:0]      ones_q, ones_d, tens_q, tens_d;
   logic [2:0]      balls_q, balls_d;
   logic            still_q, still_d;
   logic [1:0]      txt_q, txt_d;
   logic            btn_any;

   // Pixel counters dwell two clocks per value, so only the rising edge counts.
   assign at_vb   = (bus.pixel_x == 12'd0) && (bus.pixel_y == 12'(VD_LINE));
   assign btn_any = (bus.btn != 2'b00);

   always_comb begin
      state_d    = state_q;
      ones_d     = ones_q;
      tens_d     = tens_q;
      balls_d    = balls_q;
      timer_load = 1'b0;
      case (state_q)
         NEWGAME: begin
            balls_d = 3'(BALLS);
            if (btn_any) begin
               state_d = PLAY;
               balls_d = 3'(BALLS - 1);
            end
         end
         PLAY: begin
            if (bus.miss) begin
               timer_load = 1'b1;
               if (balls_q == 3'd0) begin
                  state_d = OVER;
               end else begin
                  balls_d = balls_q - 3'd1;
                  state_d = NEWBALL;
               end
            end else if (bus.hit) begin
               if (ones_q == 4'd9) begin
                  ones_d = 4'd0;
                  tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
               end else begin
                  ones_d = ones_q + 4'd1;
               end
            end
         end
         NEWBALL: begin
            if (done_q && btn_any) state_d = PLAY;
         end
         OVER: begin
            // Final score stays on screen until the countdown releases the game.
            if (done_q) begin
               state_d = NEWGAME;
               ones_d  = 4'd0;
               tens_d  = 4'd0;
               balls_d = 3'(BALLS);
            end
         end
         default: state_d = NEWGAME;
      endcase

      still_d = (state_d != PLAY);
      case (state_d)
         NEWGAME: txt_d = 2'b01;
         OVER:    txt_d = 2'b10;
         default: txt_d = 2'b00;
      endcase

      if (timer_load)                       cnt_d = TW'(TIMER_FRAMES);
      else if (tick_q && (cnt_q != '0))     cnt_d = cnt_q - TW'(1);
      else                                  cnt_d = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= NEWGAME;
         at_vb_q <= 1'b0;
         tick_q  <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b1;
         ones_q  <= 4'd0;
         tens_q  <= 4'd0;
         balls_q <= 3'(BALLS);
         still_q <= 1'b1;
         txt_q   <= 2'b01;
      end else begin
         state_q <= state_d;
         at_vb_q <= at_vb;
         tick_q  <= at_vb & ~at_vb_q;
         cnt_q   <= cnt_d;
         done_q  <= (cnt_d == '0);
         ones_q  <= ones_d;
         tens_q  <= tens_d;
         balls_q <= balls_d;
         still_q <= still_d;
         txt_q   <= txt_d;
      end
   end

   assign bus.frame_tick = tick_q;
   assign bus.state      = state_q;
   assign bus.gra_still  = still_q;
   assign bus.text_sel   = txt_q;
   assign bus.score      = {tens_q, ones_q};
   assign bus.balls_left = balls_q;
   assign bus.timer_done = done_q;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the pong display path. It watches the pixel counters from the VGA sync generator and derives a one-clock frame tick at the start of vertical blank. It runs the game state machine (new game, play, new ball, game over) and keeps the BCD score, the balls-remaining count and a frame-based countdown timer. Its outputs freeze or release the graphics datapath and select the text overlay.

Parameters:
VD_LINE, 480, pixel_y value that marks the first vertical-blank line; the frame tick fires here
TIMER_FRAMES, 120, countdown length in frames (2 s at 60 Hz)
BALLS, 3, balls per game; range 1..7

Ports:
clk  in  1  system clock, same clock that drives vga_sync
rst  in  1  synchronous, active-high reset
pixel_x  in  12  horizontal pixel counter from vga_sync
pixel_y  in  12  vertical pixel counter from vga_sync
btn  in  2  player buttons, level, already debounced
hit  in  1  one-clk pulse: paddle hit the ball
miss  in  1  one-clk pulse: ball passed the paddle
frame_tick  out  1  one-clk pulse at start of vertical blank
state  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
gra_still  out  1  1 = graphics datapath frozen, ball parked
text_sel  out  2  overlay select: 00 none, 01 rules/start, 10 game over
score  out  8  two-digit BCD score, {tens, ones}
balls_left  out  3  balls remaining
timer_done  out  1  level, 1 while the countdown value is 0

Behaviour:
- All outputs are registered. Everything changes only on the rising edge of clk; rst is sampled on the clock edge.
- Reset values:
  - state=NEWGAME, gra_still=1, text_sel=01
  - score=8'h00, balls_left=BALLS
  - timer value=0, so timer_done=1
  - frame_tick=0
- Frame tick:
  - Let at_vb = (pixel_x==0 && pixel_y==VD_LINE); keep a registered copy of at_vb.
  - frame_tick=1 for exactly one clk, the cycle after at_vb first rises. The pixel counters hold for two clk cycles, so the edge detect is required.
  - Result: one tick per frame, latency 1 clk from the first cycle at_vb is seen.
- Timer:
  - An internal load strobe sets the count to TIMER_FRAMES.
  - Otherwise the count decrements by 1 on frame_tick while nonzero, and saturates at 0.
  - If load and frame_tick occur in the same cycle, load wins.
  - timer_done = (count==0), registered.
- State machine (transitions take effect on the next clk):
  - NEWGAME: gra_still=1, text_sel=01, score held at 0, balls_left=BALLS.
    - If btn != 0: go to PLAY and set balls_left = BALLS-1.
  - PLAY: gra_still=0, text_sel=00.
    - On hit, with no miss in the same cycle: score increments in BCD. Ones 9 rolls to 0 with tens+1; 99 wraps to 00.
    - On miss:
      - If balls_left==0: go to OVER and load the timer.
      - Else: decrement balls_left, go to NEWBALL, load the timer.
    - hit and miss in the same cycle: miss wins, score unchanged.
  - NEWBALL: gra_still=1, text_sel=00.
    - Go to PLAY when timer_done==1 and btn != 0.
    - The timer_done checked is the registered value, so the first eligible cycle is after the count reaches 0.
  - OVER: gra_still=1, text_sel=10.
    - When timer_done==1: go to NEWGAME and clear score to 0.
    - btn is ignored in this state.
- hit and miss are ignored outside PLAY. btn is ignored in PLAY and OVER.
- Reset mid-game: returns to NEWGAME reset values on the next edge, from any state, and discards any pending timer count.
- The score is never cleared on the NEWGAME→PLAY transition. It clears only on reset or on leaving OVER, so the final score stays visible during OVER.

Test Plan:
- Reset, then free-run vga_sync for 3 frames → exactly 3 frame_tick pulses, each 1 clk wide, 800*525*2 clk apart; state=00, balls_left=3, score=00.
- In NEWGAME pulse btn=01 → next clk state=01, balls_left=2, gra_still=0; then 12 hit pulses → score=8'h12.
- Set score to 99 via 99 hits, then 1 more hit → score=8'h00.
- In PLAY pulse miss → state=10, timer=120. Hold btn=01 before the timer expires → stays NEWBALL. After 120 frame_ticks timer_done=1 → state=01 on the following clk.
- hit and miss asserted in the same cycle with score=8'h05 → score stays 8'h05, balls_left decrements.
- Three misses from a fresh game → state=11, text_sel=10, score retained. After 120 frames → state=00, score=00. Assert rst mid-countdown → state=00, timer_done=1 next clk.
